// File: rtl/s15850_vec_tx.sv
// Framed 20-bit stimulus transmitter for the s15850 n460 checker: zero/one markers, walking one, then LFSR frames.
// Optional response signature register enabled by defining RESP_MISR_EN.
module s15850_vec_tx #(
    parameter logic [19:0] SEED       = 20'h00001,
    parameter int          NUM_FRAMES = 256,
    parameter int          CNT_W      = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [19:0]      vec,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy,
    output logic             done
`ifdef RESP_MISR_EN
    ,
    input  logic             resp,
    input  logic             resp_valid,
    output logic [15:0]      signature
`endif
);

    localparam logic [19:0] SEED_EFF  = (SEED == 20'h00000) ? 20'h00001 : SEED;
    localparam int          RW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [RW-1:0] RAND_LAST = RW'((NUM_FRAMES > 0) ? NUM_FRAMES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        MARK0,
        MARK1,
        WALK,
        RAND,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [19:0]       vec_q, vec_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [19:0]       lfsr_q, lfsr_d;
    logic [4:0]        idx_q, idx_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              xfer;
    logic              start_acc;

    assign xfer      = valid_q & vec_ready;
    assign start_acc = start & ((state_q == IDLE) | (state_q == DONE));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        rcnt_d  = rcnt_q;

        if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = MARK0;
                    vec_d   = '0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    lfsr_d  = SEED_EFF;
                    idx_d   = '0;
                    rcnt_d  = '0;
                end
            end
            MARK0: begin
                if (xfer) begin
                    state_d = MARK1;
                    vec_d   = '1;
                end
            end
            MARK1: begin
                if (xfer) begin
                    state_d = WALK;
                    vec_d   = 20'h00001;
                end
            end
            WALK: begin
                if (xfer) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 5'd19) begin
                        if (NUM_FRAMES == 0) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                        end else begin
                            state_d = RAND;
                            vec_d   = lfsr_q;
                        end
                    end else begin
                        vec_d = vec_q << 1;
                    end
                end
            end
            RAND: begin
                if (xfer) begin
                    // x^20+x^17+1; the frame just accepted was lfsr_q, so present the stepped value
                    lfsr_d = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == RAND_LAST) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else begin
                        vec_d = lfsr_d;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            vec_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            lfsr_q  <= SEED_EFF;
            idx_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign vec       = vec_q;
    assign vec_valid = valid_q;
    assign frame_cnt = cnt_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);

`ifdef RESP_MISR_EN
    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (start_acc) begin
            sig_d = '1;
        end else if (resp_valid) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {15'b0, resp};
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            sig_q <= '1;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`endif

endmodule

// File: tb/tb_s15850_vec_tx.sv
// Bench for s15850_vec_tx: two instances (NUM_FRAMES=4 with SEED=0, and NUM_FRAMES=0) checked every cycle
// against a frame-index model, plus directed literal checks.
module tb_s15850_vec_tx;

    localparam int CNT_W = 16;
    localparam int          NF [2] = '{4, 0};
    localparam logic [19:0] SD [2] = '{20'h00000, 20'h00001};

    logic CK = 1'b0;
    logic RST, start, vec_ready;
    logic resp, resp_valid;

    logic             valid_w [2];
    logic [19:0]      vec_w   [2];
    logic [CNT_W-1:0] cnt_w   [2];
    logic             busy_w  [2];
    logic             done_w  [2];
`ifdef RESP_MISR_EN
    logic [15:0]      sig_w   [2];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CK = ~CK;

    s15850_vec_tx #(.SEED(20'h00000), .NUM_FRAMES(4), .CNT_W(CNT_W)) u_dut_a (
        .CK(CK), .RST(RST), .start(start),
        .vec_valid(valid_w[0]), .vec_ready(vec_ready), .vec(vec_w[0]),
        .frame_cnt(cnt_w[0]), .busy(busy_w[0]), .done(done_w[0])
`ifdef RESP_MISR_EN
        , .resp(resp), .resp_valid(resp_valid), .signature(sig_w[0])
`endif
    );

    s15850_vec_tx #(.SEED(20'h00001), .NUM_FRAMES(0), .CNT_W(CNT_W)) u_dut_b (
        .CK(CK), .RST(RST), .start(start),
        .vec_valid(valid_w[1]), .vec_ready(vec_ready), .vec(vec_w[1]),
        .frame_cnt(cnt_w[1]), .busy(busy_w[1]), .done(done_w[1])
`ifdef RESP_MISR_EN
        , .resp(resp), .resp_valid(resp_valid), .signature(sig_w[1])
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Frame k of a run: two markers, twenty walking-one frames, then successive LFSR states.
    function automatic logic [19:0] frame_at(input int k, input logic [19:0] seed);
        logic [19:0] l;
        logic [19:0] one;
        one = 20'h00001;
        if (k == 0) return 20'h00000;
        if (k == 1) return 20'hFFFFF;
        if (k < 22) return one << (k - 2);
        l = (seed == 20'h00000) ? 20'h00001 : seed;
        for (int s = 0; s < k - 22; s++) l = {l[18:0], l[19] ^ l[16]};
        return l;
    endfunction

    bit          model_ok = 1'b0;
    bit          m_act  [2] = '{1'b0, 1'b0};
    bit          m_done [2] = '{1'b0, 1'b0};
    int          m_k    [2] = '{0, 0};
    logic [19:0] m_last [2] = '{20'h0, 20'h0};
    logic [15:0] m_sig  [2] = '{16'hFFFF, 16'hFFFF};

    always @(posedge CK) begin
        if (RST) model_ok <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_act[i] <= 1'b0; m_done[i] <= 1'b0; m_k[i] <= 0; m_last[i] <= 20'h0;
                m_sig[i] <= 16'hFFFF;
            end else begin
                if (start && !m_act[i]) begin
                    m_act[i] <= 1'b1; m_done[i] <= 1'b0; m_k[i] <= 0;
                    m_sig[i] <= 16'hFFFF;
                end else begin
                    if (m_act[i] && vec_ready) begin
                        m_last[i] <= frame_at(m_k[i], SD[i]);
                        m_k[i]    <= m_k[i] + 1;
                        if (m_k[i] + 1 == 22 + NF[i]) begin
                            m_act[i] <= 1'b0; m_done[i] <= 1'b1;
                        end
                    end
                    if (resp_valid)
                        m_sig[i] <= {m_sig[i][14:0], 1'b0} ^ (m_sig[i][15] ? 16'h1021 : 16'h0) ^ {15'b0, resp};
                end
            end
        end
    end

    always @(negedge CK) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d_valid", i), 32'(valid_w[i]), 32'(m_act[i]));
                chk($sformatf("u%0d_vec", i), 32'(vec_w[i]),
                    32'(m_act[i] ? frame_at(m_k[i], SD[i]) : m_last[i]));
                chk($sformatf("u%0d_cnt", i), 32'(cnt_w[i]), 32'(16'(m_k[i])));
                chk($sformatf("u%0d_busy", i), 32'(busy_w[i]), 32'(m_act[i]));
                chk($sformatf("u%0d_done", i), 32'(done_w[i]), 32'(m_done[i]));
`ifdef RESP_MISR_EN
                chk($sformatf("u%0d_sig", i), 32'(sig_w[i]), 32'(m_sig[i]));
`endif
            end
        end
    end

    task automatic wait_cnt(input int c, input string nm);
        int n = 0;
        while (int'(cnt_w[0]) != c && n < 300) begin
            @(negedge CK);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL %s: timeout, frame_cnt %0d expected %0d", nm, cnt_w[0], c);
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_w[0] !== 1'b1 && n < 300) begin
            @(negedge CK);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL %s: timeout, done %b expected 1", nm, done_w[0]);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; vec_ready = 1'b1; resp = 1'b0; resp_valid = 1'b0;
        repeat (2) @(negedge CK);
        chk("rst_vec", 32'(vec_w[0]), 32'h0);
        chk("rst_valid", 32'(valid_w[0]), 32'h0);
        chk("rst_busy", 32'(busy_w[0]), 32'h0);
        chk("rst_done", 32'(done_w[0]), 32'h0);
        chk("rst_cnt", 32'(cnt_w[0]), 32'h0);
        RST = 1'b0;
`ifdef RESP_MISR_EN
        chk("sig_rst", 32'(sig_w[0]), 32'hFFFF);
        @(negedge CK);
        chk("sig_idle_hold", 32'(sig_w[0]), 32'hFFFF);
        resp_valid = 1'b1; resp = 1'b1;
        @(negedge CK);
        resp_valid = 1'b0; resp = 1'b0;
        chk("sig_one", 32'(sig_w[0]), 32'hEFDE);
`endif
        @(negedge CK);
        pulse_start();
        chk("run1_first_vec", 32'(vec_w[0]), 32'h0);
        chk("run1_first_valid", 32'(valid_w[0]), 32'h1);

        // backpressure with walk index 5 on the bus
        wait_cnt(7, "bp_reach");
        vec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            chk("bp_vec", 32'(vec_w[0]), 32'h00020);
            chk("bp_valid", 32'(valid_w[0]), 32'h1);
            chk("bp_cnt", 32'(cnt_w[0]), 32'd7);
        end
        vec_ready = 1'b1;
        @(negedge CK);
        chk("bp_next_vec", 32'(vec_w[0]), 32'h00040);
        chk("bp_next_cnt", 32'(cnt_w[0]), 32'd8);

        wait_cnt(22, "rand_reach");
        chk("rand_first_vec", 32'(vec_w[0]), 32'h00001);
        chk("nf0_done", 32'(done_w[1]), 32'h1);
        chk("nf0_cnt", 32'(cnt_w[1]), 32'd22);
        chk("nf0_last_vec", 32'(vec_w[1]), 32'h80000);
        @(negedge CK);
        chk("rand_second_vec", 32'(vec_w[0]), 32'h00002);
        pulse_start();

        wait_done("run1_done");
        chk("run1_cnt", 32'(cnt_w[0]), 32'd26);
        chk("run1_valid_low", 32'(valid_w[0]), 32'h0);
        chk("run1_last_vec", 32'(vec_w[0]), 32'h00008);
        @(negedge CK);
        pulse_start();
        chk("restart_cnt", 32'(cnt_w[0]), 32'd0);
        chk("restart_vec", 32'(vec_w[0]), 32'h0);
        chk("restart_valid", 32'(valid_w[0]), 32'h1);

        // reset in the middle of the walk (index 10 presented)
        wait_cnt(12, "walk10_reach");
        chk("walk10_vec", 32'(vec_w[0]), 32'h00400);
        RST = 1'b1;
        start = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        start = 1'b0;
        chk("midrst_valid", 32'(valid_w[0]), 32'h0);
        chk("midrst_busy", 32'(busy_w[0]), 32'h0);
        chk("midrst_cnt", 32'(cnt_w[0]), 32'h0);
        chk("midrst_vec", 32'(vec_w[0]), 32'h0);
        @(negedge CK);
        pulse_start();
        chk("replay_vec", 32'(vec_w[0]), 32'h0);

        for (int i = 0; i < 30; i++) begin
            vec_ready = (i % 3) != 0;
            @(negedge CK);
        end
        vec_ready = 1'b1;
        wait_done("run3_done");
        chk("run3_cnt", 32'(cnt_w[0]), 32'd26);
        repeat (3) @(negedge CK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
